// File: rtl/fetch_sequencer_if.sv
// Bundle between the fetch sequencer, the byte-wide instruction memory,
// the branch unit (redirects) and the IF/ID stage.
interface fetch_sequencer_if #(
    parameter int ADDR_W = 64
);
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_rdata;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              inst_valid;
    logic              inst_ready;
    logic [31:0]       inst;
    logic [ADDR_W-1:0] inst_pc;
    logic              fault;

    modport master (
        output mem_addr, inst_valid, inst, inst_pc, fault,
        input  mem_rdata, redirect_valid, redirect_pc, inst_ready
    );

    modport slave (
        input  mem_addr, inst_valid, inst, inst_pc, fault,
        output mem_rdata, redirect_valid, redirect_pc, inst_ready
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Fetches four bytes per instruction from a combinational byte memory,
// assembles them little-endian and hands them to IF/ID over valid/ready.
module fetch_sequencer #(
    parameter int                ADDR_W    = 64,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter int                MEM_BYTES = 88
) (
    input  logic               clk,
    input  logic               reset_n,
    fetch_sequencer_if.master  bus
);
    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_HOLD  = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    // Highest aligned start address whose last byte is still inside memory.
    localparam logic [ADDR_W-1:0] LAST_PC = ADDR_W'(MEM_BYTES - 4);

    state_t            r_state, w_state_next;
    logic [ADDR_W-1:0] r_pc, w_pc_next;
    logic [1:0]        r_byte_cnt, w_byte_cnt_next;
    logic [31:0]       r_inst, w_inst_next;
    logic [ADDR_W-1:0] r_inst_pc, w_inst_pc_next;
    logic              r_inst_valid, w_inst_valid_next;
    logic              r_fault, w_fault_next;
    logic              w_bad_pc;

    assign w_bad_pc = (r_pc[1:0] != 2'b00) || (r_pc > LAST_PC);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_FETCH;
            r_pc         <= RESET_PC;
            r_byte_cnt   <= 2'd0;
            r_inst       <= 32'd0;
            r_inst_pc    <= '0;
            r_inst_valid <= 1'b0;
            r_fault      <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_pc         <= w_pc_next;
            r_byte_cnt   <= w_byte_cnt_next;
            r_inst       <= w_inst_next;
            r_inst_pc    <= w_inst_pc_next;
            r_inst_valid <= w_inst_valid_next;
            r_fault      <= w_fault_next;
        end
    end

    always_comb begin
        w_state_next      = r_state;
        w_pc_next         = r_pc;
        w_byte_cnt_next   = r_byte_cnt;
        w_inst_next       = r_inst;
        w_inst_pc_next    = r_inst_pc;
        w_inst_valid_next = r_inst_valid;
        w_fault_next      = r_fault;
        unique case (r_state)
            ST_FETCH: begin
                if (bus.redirect_valid) begin
                    w_pc_next         = bus.redirect_pc;
                    w_byte_cnt_next   = 2'd0;
                    w_inst_valid_next = 1'b0;
                end else if ((r_byte_cnt == 2'd0) && w_bad_pc) begin
                    w_state_next = ST_FAULT;
                    w_fault_next = 1'b1;
                end else begin
                    w_inst_next[{r_byte_cnt, 3'b000} +: 8] = bus.mem_rdata;
                    w_byte_cnt_next = r_byte_cnt + 2'd1;
                    if (r_byte_cnt == 2'd3) begin
                        w_inst_pc_next    = r_pc;
                        w_inst_valid_next = 1'b1;
                        w_byte_cnt_next   = 2'd0;
                        w_state_next      = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                // A redirect alongside a handshake still lets the beat complete.
                if (bus.redirect_valid) begin
                    w_pc_next         = bus.redirect_pc;
                    w_byte_cnt_next   = 2'd0;
                    w_inst_valid_next = 1'b0;
                    w_state_next      = ST_FETCH;
                end else if (r_inst_valid && bus.inst_ready) begin
                    w_inst_valid_next = 1'b0;
                    w_pc_next         = r_pc + ADDR_W'(4);
                    w_state_next      = ST_FETCH;
                end
            end
            ST_FAULT: begin
                w_fault_next      = 1'b1;
                w_inst_valid_next = 1'b0;
            end
            default: begin
                w_state_next = ST_FETCH;
            end
        endcase
    end

    assign bus.mem_addr   = (r_state == ST_FETCH) ? (r_pc + ADDR_W'(r_byte_cnt)) : r_pc;
    assign bus.inst       = r_inst;
    assign bus.inst_pc    = r_inst_pc;
    assign bus.inst_valid = r_inst_valid;
    assign bus.fault      = r_fault;
endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: expected instructions are queued as
// stimulus is set up and popped as the DUT presents them.
module tb_fetch_sequencer;
    localparam int ADDR_W    = 64;
    localparam int MEM_BYTES = 88;

    typedef struct packed {
        logic [31:0]       inst;
        logic [ADDR_W-1:0] pc;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;
    exp_t sb[$];
    logic [7:0] mem [0:MEM_BYTES-1];

    fetch_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

    fetch_sequencer #(
        .ADDR_W(ADDR_W),
        .RESET_PC('0),
        .MEM_BYTES(MEM_BYTES)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always_comb begin
        bus.mem_rdata = 8'h00;
        if (bus.mem_addr < 64'(MEM_BYTES))
            bus.mem_rdata = mem[bus.mem_addr[6:0]];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input int max_cycles, output int cycles);
        cycles = -1;
        for (int i = 1; i <= max_cycles; i++) begin
            tick();
            if (bus.inst_valid === 1'b1) begin
                cycles = i;
                break;
            end
        end
    endtask

    task automatic pop_expect(output exp_t e);
        e = '0;
        if (sb.size() > 0) e = sb.pop_front();
    endtask

    task automatic restart(input logic ready);
        reset_n = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = '0;
        bus.inst_ready = 1'b0;
        tick();
        bus.inst_ready = ready;
        reset_n = 1'b1;
    endtask

    // Waits for the next valid beat and checks latency, data and PC against the queue head.
    task automatic expect_beat(input string name, input int lat);
        int   c;
        exp_t e;
        wait_valid(lat + 4, c);
        pop_expect(e);
        $display("txn %s: pc=%h inst=%h after %0d cycles", name, bus.inst_pc, bus.inst, c);
        n_vec++;
        if (c !== lat) begin n_err++; $display("FAIL %s latency: got %0d expected %0d", name, c, lat); end
        n_vec++;
        if (bus.inst !== e.inst) begin n_err++; $display("FAIL %s inst: got %h expected %h", name, bus.inst, e.inst); end
        n_vec++;
        if (bus.inst_pc !== e.pc) begin n_err++; $display("FAIL %s inst_pc: got %h expected %h", name, bus.inst_pc, e.pc); end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = '0;
        bus.inst_ready = 1'b0;
        tick();
        tick();
        n_vec++;
        if (bus.inst_valid !== 1'b0) begin n_err++; $display("FAIL reset inst_valid: got %b expected 0", bus.inst_valid); end
        n_vec++;
        if (bus.fault !== 1'b0) begin n_err++; $display("FAIL reset fault: got %b expected 0", bus.fault); end
        n_vec++;
        if (bus.inst !== 32'd0) begin n_err++; $display("FAIL reset inst: got %h expected 0", bus.inst); end
        n_vec++;
        if (bus.inst_pc !== 64'd0) begin n_err++; $display("FAIL reset inst_pc: got %h expected 0", bus.inst_pc); end
        n_vec++;
        if (bus.mem_addr !== 64'd0) begin n_err++; $display("FAIL reset mem_addr: got %h expected 0", bus.mem_addr); end
    endtask

    task automatic test_stream();
        restart(1'b1);
        sb.push_back('{inst: 32'h02853483, pc: 64'h0});
        sb.push_back('{inst: 32'h009A84B3, pc: 64'h4});
        sb.push_back('{inst: 32'h00148493, pc: 64'h8});
        sb.push_back('{inst: 32'h02953423, pc: 64'hC});
        expect_beat("stream0", 4);
        expect_beat("stream1", 5);
        expect_beat("stream2", 5);
        expect_beat("stream3", 5);
    endtask

    task automatic test_backpressure();
        restart(1'b0);
        sb.push_back('{inst: 32'h02853483, pc: 64'h0});
        sb.push_back('{inst: 32'h009A84B3, pc: 64'h4});
        expect_beat("bp_first", 4);
        for (int i = 0; i < 6; i++) begin
            if (i > 0) tick();
            n_vec++;
            if (bus.inst_valid !== 1'b1 || bus.inst !== 32'h02853483 || bus.inst_pc !== 64'h0 || bus.mem_addr !== 64'h0) begin
                n_err++;
                $display("FAIL bp_hold cycle %0d: got v=%b inst=%h pc=%h addr=%h expected v=1 inst=02853483 pc=0 addr=0",
                         i, bus.inst_valid, bus.inst, bus.inst_pc, bus.mem_addr);
            end
        end
        bus.inst_ready = 1'b1;
        tick();
        n_vec++;
        if (bus.inst_valid !== 1'b0 || bus.mem_addr !== 64'h4) begin
            n_err++;
            $display("FAIL bp_release: got v=%b addr=%h expected v=0 addr=4", bus.inst_valid, bus.mem_addr);
        end
        expect_beat("bp_second", 4);
    endtask

    task automatic test_redirect_mid();
        restart(1'b1);
        sb.push_back('{inst: 32'h02853483, pc: 64'h0});
        sb.push_back('{inst: 32'h02953423, pc: 64'hC});
        expect_beat("rmid_first", 4);
        tick();
        tick();
        tick();
        n_vec++;
        if (bus.mem_addr !== 64'h6) begin n_err++; $display("FAIL rmid_bytecnt2 mem_addr: got %h expected 6", bus.mem_addr); end
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 64'hC;
        tick();
        bus.redirect_valid = 1'b0;
        n_vec++;
        if (bus.inst_valid !== 1'b0 || bus.mem_addr !== 64'hC) begin
            n_err++;
            $display("FAIL rmid_after: got v=%b addr=%h expected v=0 addr=c", bus.inst_valid, bus.mem_addr);
        end
        expect_beat("rmid_target", 4);
    endtask

    task automatic test_redirect_handshake();
        restart(1'b1);
        sb.push_back('{inst: 32'h02853483, pc: 64'h0});
        sb.push_back('{inst: 32'h00148493, pc: 64'h8});
        expect_beat("rhs_first", 4);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 64'h8;
        tick();
        bus.redirect_valid = 1'b0;
        n_vec++;
        if (bus.inst_valid !== 1'b0 || bus.mem_addr !== 64'h8) begin
            n_err++;
            $display("FAIL rhs_single_beat: got v=%b addr=%h expected v=0 addr=8", bus.inst_valid, bus.mem_addr);
        end
        expect_beat("rhs_target", 4);
    endtask

    task automatic test_fault();
        logic [ADDR_W-1:0] bad_pcs [2];
        exp_t e;
        bad_pcs[0] = 64'h6;
        bad_pcs[1] = 64'h58;
        foreach (bad_pcs[k]) begin
            restart(1'b1);
            bus.redirect_valid = 1'b1;
            bus.redirect_pc = bad_pcs[k];
            tick();
            bus.redirect_valid = 1'b0;
            tick();
            n_vec++;
            if (bus.fault !== 1'b1 || bus.inst_valid !== 1'b0 || bus.mem_addr !== bad_pcs[k]) begin
                n_err++;
                $display("FAIL fault_%0h: got f=%b v=%b addr=%h expected f=1 v=0 addr=%h",
                         bad_pcs[k], bus.fault, bus.inst_valid, bus.mem_addr, bad_pcs[k]);
            end
            bus.redirect_valid = 1'b1;
            bus.redirect_pc = 64'h0;
            repeat (3) tick();
            bus.redirect_valid = 1'b0;
            n_vec++;
            if (bus.fault !== 1'b1 || bus.inst_valid !== 1'b0 || bus.mem_addr !== bad_pcs[k]) begin
                n_err++;
                $display("FAIL fault_sticky_%0h: got f=%b v=%b addr=%h expected f=1 v=0 addr=%h",
                         bad_pcs[k], bus.fault, bus.inst_valid, bus.mem_addr, bad_pcs[k]);
            end
            #2;
            reset_n = 1'b0;
            #1;
            n_vec++;
            if (bus.fault !== 1'b0) begin n_err++; $display("FAIL fault_clear_%0h: got %b expected 0", bad_pcs[k], bus.fault); end
        end
        // Last legal start address: bytes 84..87 are all in range.
        restart(1'b1);
        e.inst = {mem[87], mem[86], mem[85], mem[84]};
        e.pc = 64'h54;
        sb.push_back(e);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 64'h54;
        tick();
        bus.redirect_valid = 1'b0;
        expect_beat("edge_0x54", 4);
        n_vec++;
        if (bus.fault !== 1'b0) begin n_err++; $display("FAIL edge_0x54 fault: got %b expected 0", bus.fault); end
    endtask

    task automatic test_async_reset();
        restart(1'b1);
        sb.push_back('{inst: 32'h02853483, pc: 64'h0});
        sb.push_back('{inst: 32'h009A84B3, pc: 64'h4});
        sb.push_back('{inst: 32'h02853483, pc: 64'h0});
        expect_beat("ar_first", 4);
        expect_beat("ar_second", 5);
        tick();
        tick();
        n_vec++;
        if (bus.mem_addr !== 64'h9) begin n_err++; $display("FAIL ar_midfetch mem_addr: got %h expected 9", bus.mem_addr); end
        #3;
        reset_n = 1'b0;
        #1;
        n_vec++;
        if (bus.inst_valid !== 1'b0 || bus.inst !== 32'd0 || bus.inst_pc !== 64'd0 || bus.mem_addr !== 64'd0 || bus.fault !== 1'b0) begin
            n_err++;
            $display("FAIL ar_immediate: got v=%b inst=%h pc=%h addr=%h f=%b expected all 0",
                     bus.inst_valid, bus.inst, bus.inst_pc, bus.mem_addr, bus.fault);
        end
        tick();
        reset_n = 1'b1;
        expect_beat("ar_restart", 4);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] head [16];
        head = '{8'h83, 8'h34, 8'h85, 8'h02, 8'hB3, 8'h84, 8'h9A, 8'h00,
                 8'h93, 8'h84, 8'h14, 8'h00, 8'h23, 8'h34, 8'h95, 8'h02};
        for (int i = 0; i < MEM_BYTES; i++) begin
            if (i < 16) mem[i] = head[i];
            else        mem[i] = 8'((i * 7) + 3);
        end
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_mid();
        test_redirect_handshake();
        test_fault();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Sequences the byte-wide, byte-addressed instruction memory (combinational read, 8-bit data per address).
- Reads four consecutive bytes, one per cycle, and assembles them little-endian into a 32-bit instruction.
- Presents the instruction with its PC to the IF/ID stage over a valid/ready handshake.
- Handles PC increment, branch/jump redirects and address faults.

Parameters:
- ADDR_W, 64, width of PC and memory address.
- RESET_PC, 0, PC loaded on reset.
- MEM_BYTES, 88, instruction memory size in bytes; legal fetch requires pc+3 <= MEM_BYTES-1.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- mem_addr  out  ADDR_W  byte address to instruction memory.
- mem_rdata  in  8  byte returned combinationally for mem_addr.
- redirect_valid  in  1  branch/jump taken; load redirect_pc.
- redirect_pc  in  ADDR_W  new fetch address.
- inst_valid  out  1  inst/inst_pc hold a complete instruction.
- inst_ready  in  1  IF/ID stage accepts the instruction.
- inst  out  32  assembled instruction.
- inst_pc  out  ADDR_W  address of inst.
- fault  out  1  sticky misaligned/out-of-range fetch error.

Behaviour:
- Reset (async, reset_n=0):
  - State FETCH, pc=RESET_PC, byte_cnt=0.
  - inst=0, inst_pc=0, inst_valid=0, fault=0.
  - mem_addr=RESET_PC.
  - Reset mid-fetch discards the partial instruction.
- mem_addr = pc + byte_cnt in FETCH, and pc in every other state; ADDR_W-bit arithmetic, wraps modulo 2^ADDR_W.
- FSM states: FETCH, HOLD, FAULT.
- FETCH:
  - Before byte 0 is captured, check pc: pc[1:0]!=0 or pc+3 > MEM_BYTES-1 -> FAULT (fault=1 next cycle, nothing captured).
  - Otherwise, each cycle, capture mem_rdata into inst byte lane byte_cnt (lane 0 = inst[7:0]), then byte_cnt++.
  - After the byte_cnt==3 capture: inst_pc<=pc, inst_valid<=1, byte_cnt<=0, go HOLD.
  - Latency: 4 cycles from entering FETCH to inst_valid=1.
- HOLD:
  - inst and inst_pc stable while inst_valid=1 and inst_ready=0.
  - On inst_valid&inst_ready: inst_valid<=0, pc<=pc+4, go FETCH.
  - Throughput: 1 instruction per 5 cycles with inst_ready held at 1.
- Redirect (redirect_valid=1) has highest priority in FETCH and HOLD:
  - Next cycle: pc<=redirect_pc, byte_cnt<=0, inst_valid<=0, state FETCH.
  - Any partial bytes are abandoned.
  - Redirect in the same cycle as a handshake: the transfer completes (consumer sees one valid beat) and the next fetch starts at redirect_pc, not pc+4.
  - A misaligned or out-of-range redirect_pc faults in the first FETCH cycle, per the check above.
- FAULT:
  - fault=1, inst_valid=0, mem_addr=pc (offending address).
  - Ignores redirect_valid and inst_ready; exits only on reset.
- inst keeps its last assembled value after handshake; consumers qualify it with inst_valid only.
- No combinational path from inst_ready or redirect_valid to any output; mem_addr depends only on registered state.

Test Plan:
- Memory bytes 0..15 = 83 34 85 02 B3 84 9A 00 93 84 14 00 23 34 95 02, inst_ready=1 after reset:
  - inst_valid pulses with inst=0x02853483/pc 0x0, then 0x009A84B3/0x4, 0x00148493/0x8, 0x02953423/0xC.
  - Valid pulses spaced 5 cycles apart.
  - First inst_valid 4 cycles after reset_n rises.
- Backpressure: inst_ready=0 for 6 cycles at the first valid -> inst=0x02853483 and inst_pc=0 held stable, mem_addr=0 throughout; second fetch starts the cycle after inst_ready=1.
- redirect_valid with redirect_pc=0xC asserted at byte_cnt=2 of fetch at pc 0x4 -> no valid for pc 0x4; next valid is inst=0x02953423, inst_pc=0xC, 4 cycles after the redirect cycle.
- Redirect coincident with handshake of inst at pc 0x0 (redirect_pc=0x8) -> exactly one valid beat for 0x0, next inst_pc=0x8, inst=0x00148493.
- Fault cases:
  - redirect_pc=0x6 -> fault=1, inst_valid stays 0, mem_addr=0x6 until reset; later redirect_valid is ignored.
  - redirect_pc=0x58 (88) -> fault=1 as well.
  - reset_n low clears fault.
- Async reset mid-fetch (byte_cnt=1, pc=0x8) -> outputs clear immediately without a clock edge; after release, the first instruction is from RESET_PC with no stale bytes.
